// File: rtl/extram_arb_pkg.sv
// -----------------------------------------------------------------------------
// extram_arb_pkg
// Shared types and constants for the two-port external-RAM arbiter.
//   state_e      : arbiter FSM states (IDLE, ACCESS, RESP)
//   CNT_W        : width of the read-latency counter (READ_LATENCY <= 15)
//   GNT_CPU/DMA  : grant identifiers for port 0 (CPU) and port 1 (DMA)
//   access_count : counter preload for a new transaction
// -----------------------------------------------------------------------------
package extram_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DMA = 1'b1;

    // Writes occupy a single ACCESS cycle; reads hold ACCESS for the RAM latency.
    function automatic logic [CNT_W-1:0] access_count(input logic        is_write,
                                                       input int unsigned lat);
        logic [CNT_W-1:0] cnt;
        cnt = is_write ? '0 : CNT_W'(lat - 1);
        return cnt;
    endfunction

endpackage

// File: rtl/extram_arb_if.sv
// -----------------------------------------------------------------------------
// extram_arb_if
// Bundles both requester ports (m0 = CPU, m1 = DMA) and the external-RAM pins.
//   m0_valid/addr/wdata/wstrb : CPU request, wstrb==0 means read
//   m0_ready/rdata            : CPU one-cycle completion pulse and read data
//   m1_*                      : same for the DMA engine
//   extram_a/d_out/cs/oe/wstrb: RAM address, write data and strobes
//   extram_d_in               : RAM read data
// Modports:
//   slave  : arbiter view (requests in, completions and RAM strobes out)
//   master : environment view (requesters plus the RAM device)
// -----------------------------------------------------------------------------
interface extram_arb_if #(
    parameter int unsigned ADDR_W = 16
);

    logic              m0_valid;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata;
    logic [3:0]        m0_wstrb;
    logic              m0_ready;
    logic [31:0]       m0_rdata;

    logic              m1_valid;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic [3:0]        m1_wstrb;
    logic              m1_ready;
    logic [31:0]       m1_rdata;

    logic [ADDR_W-1:0] extram_a;
    logic [31:0]       extram_d_out;
    logic [31:0]       extram_d_in;
    logic              extram_cs;
    logic              extram_oe;
    logic [3:0]        extram_wstrb;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  extram_d_in,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output extram_a, extram_d_out, extram_cs, extram_oe, extram_wstrb
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output extram_d_in,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  extram_a, extram_d_out, extram_cs, extram_oe, extram_wstrb
    );

endinterface

// File: rtl/extram_arb_pick.sv
// -----------------------------------------------------------------------------
// extram_arb_pick
// Combinational winner selection for the extram arbiter.
// Ports:
//   m0_valid   in  CPU request pending
//   m1_valid   in  DMA request pending
//   last_grant in  grant id of the most recently completed transaction
//   any_valid  out at least one request pending
//   grant      out winning port (GNT_CPU / GNT_DMA), meaningful when any_valid
// Build option:
//   EXTRAM_ARB_ROUND_ROBIN_EN defined   : on contention grant the port that did
//                                         not win last time
//   EXTRAM_ARB_ROUND_ROBIN_EN undefined : fixed priority, DMA beats CPU
// -----------------------------------------------------------------------------
module extram_arb_pick
    import extram_arb_pkg::*;
(
    input  logic m0_valid,
    input  logic m1_valid,
    input  logic last_grant,
    output logic any_valid,
    output logic grant
);

`ifdef EXTRAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        any_valid = m0_valid | m1_valid;
        grant     = GNT_CPU;
        if (m0_valid && m1_valid) begin
            grant = ~last_grant;
        end else if (m1_valid) begin
            grant = GNT_DMA;
        end
    end
`else
    // History is tracked by the FSM in both builds but only consumed by round robin.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        any_valid = m0_valid | m1_valid;
        grant     = m1_valid ? GNT_DMA : GNT_CPU;
    end
`endif

endmodule

// File: rtl/extram_arbiter.sv
// -----------------------------------------------------------------------------
// extram_arbiter
// Shares one external-RAM port between the CPU (m0) and a DMA engine (m1).
// A granted request is registered in IDLE, presented to the RAM for one cycle
// (write) or READ_LATENCY cycles (read), then completed with a one-cycle ready
// pulse carrying the captured read data (zero for writes).
// Parameters:
//   READ_LATENCY : cycles from address/oe to valid extram_d_in (1..15)
//   ADDR_W       : external-RAM word-address width
// Ports:
//   clk  in  system clock, rising edge
//   nrst in  synchronous active-low reset
//   bus  --  extram_arb_if.slave: both requester ports and the RAM pins
//   busy out FSM not in IDLE
// Build option: EXTRAM_ARB_ROUND_ROBIN_EN (see extram_arb_pick).
// -----------------------------------------------------------------------------
module extram_arbiter
    import extram_arb_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic         clk,
    input  logic         nrst,
    extram_arb_if.slave  bus,
    output logic         busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              any_valid;
    logic              pick_grant;
    logic [3:0]        sel_wstrb;

    extram_arb_pick u_pick (
        .m0_valid   (bus.m0_valid),
        .m1_valid   (bus.m1_valid),
        .last_grant (last_grant_q),
        .any_valid  (any_valid),
        .grant      (pick_grant)
    );

    assign sel_wstrb = (pick_grant == GNT_DMA) ? bus.m1_wstrb : bus.m0_wstrb;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt_q        <= GNT_CPU;
            last_grant_q <= GNT_CPU;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;

        bus.extram_cs    = 1'b0;
        bus.extram_oe    = 1'b0;
        bus.extram_wstrb = 4'h0;
        bus.extram_a     = '0;
        bus.extram_d_out = '0;
        bus.m0_ready     = 1'b0;
        bus.m0_rdata     = '0;
        bus.m1_ready     = 1'b0;
        bus.m1_rdata     = '0;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_d   = pick_grant;
                    addr_d  = (pick_grant == GNT_DMA) ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = (pick_grant == GNT_DMA) ? bus.m1_wdata : bus.m0_wdata;
                    wstrb_d = sel_wstrb;
                    cnt_d   = access_count(sel_wstrb != 4'h0, READ_LATENCY);
                    // Writes complete with zero data; reads overwrite this on capture.
                    rdata_d = '0;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                bus.extram_cs    = 1'b1;
                bus.extram_a     = addr_q;
                bus.extram_d_out = wdata_q;
                if (wstrb_q != 4'h0) begin
                    bus.extram_wstrb = wstrb_q;
                end else begin
                    bus.extram_oe = 1'b1;
                end
                if (cnt_q == '0) begin
                    if (wstrb_q == 4'h0) begin
                        rdata_d = bus.extram_d_in;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RESP: begin
                if (gnt_q == GNT_DMA) begin
                    bus.m1_ready = 1'b1;
                    bus.m1_rdata = rdata_q;
                end else begin
                    bus.m0_ready = 1'b1;
                    bus.m0_rdata = rdata_q;
                end
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_extram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_extram_arbiter
// Directed bench for extram_arbiter with READ_LATENCY=2 and a word-addressed
// RAM model with byte-write enables. Single-port transactions come from a
// vector table; contention, reset and late-input-change cases are hand-written.
// -----------------------------------------------------------------------------
module tb_extram_arbiter;

    localparam int unsigned LAT    = 2;
    localparam int unsigned ADDR_W = 16;
    localparam int          BUDGET = 40;

    logic clk;
    logic nrst;
    logic busy;

    extram_arb_if #(.ADDR_W(ADDR_W)) bus ();

    extram_arbiter #(
        .READ_LATENCY (LAT),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read while oe is high, byte-merged writes.
    logic [31:0]       mem [0:65535];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [31:0]       pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.extram_cs && bus.extram_wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.extram_wstrb[b]) begin
                    mem[bus.extram_a][8*b +: 8] <= bus.extram_d_out[8*b +: 8];
                end
            end
        end
    end

    assign bus.extram_d_in = bus.extram_oe ? mem[bus.extram_a] : 32'h0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_oe;
        int          exp_we;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [7];

    task automatic drive(input logic port, input logic valid, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (port) begin
            bus.m1_valid = valid; bus.m1_addr = addr;
            bus.m1_wdata = wdata; bus.m1_wstrb = wstrb;
        end else begin
            bus.m0_valid = valid; bus.m0_addr = addr;
            bus.m0_wdata = wdata; bus.m0_wstrb = wstrb;
        end
    endtask

    task automatic preload(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // One transaction on one port; cycle 0 is the IDLE cycle the request is raised in.
    task automatic run_txn(input vec_t t, input string tag);
        int          lat = 0;
        int          oe_n = 0;
        int          we_n = 0;
        logic [31:0] rd = '0;
        logic        other = 1'b0;
        logic        bad_bus = 1'b0;
        @(negedge clk);
        drive(t.port, 1'b1, t.addr, t.wdata, t.wstrb);
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (bus.extram_oe) oe_n++;
            if (bus.extram_wstrb != 4'h0) we_n++;
            if (bus.extram_cs && (bus.extram_a !== t.addr ||
                (t.wstrb != 4'h0 && bus.extram_d_out !== t.wdata))) bad_bus = 1'b1;
            if (t.port ? (bus.m0_ready || bus.m0_rdata != 0)
                       : (bus.m1_ready || bus.m1_rdata != 0)) other = 1'b1;
            if (t.port ? bus.m1_ready : bus.m0_ready) begin
                lat = k;
                rd  = t.port ? bus.m1_rdata : bus.m0_rdata;
                break;
            end
        end
        drive(t.port, 1'b0, 16'h0, 32'h0, 4'h0);
        check({tag, " latency"}, 32'(lat), 32'(t.exp_lat));
        check({tag, " rdata"}, rd, t.exp_rdata);
        check({tag, " oe cycles"}, 32'(oe_n), 32'(t.exp_oe));
        check({tag, " wstrb cycles"}, 32'(we_n), 32'(t.exp_we));
        check({tag, " other port quiet"}, {31'b0, other}, 32'h0);
        check({tag, " ram addr/data"}, {31'b0, bad_bus}, 32'h0);
        check({tag, " ram word"}, mem[t.addr], t.exp_mem);
        @(negedge clk);
        check({tag, " idle after"}, {30'b0, busy, bus.m0_ready | bus.m1_ready}, 32'h0);
    endtask

    initial begin
        logic [3:0]  order;
        logic [3:0]  exp_order;
        int          cyc [4];
        int          n;
        int          c0;
        int          c1;
        logic        seen_rdy;

        nrst = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 16'h0, 32'h0, 4'h0);

        //               port  addr      wdata         wstrb  rdata        lat oe we mem
        vecs[0] = '{1'b0, 16'h0010, 32'h00000000, 4'h0, 32'hDEADBEEF, 3, 2, 0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 16'h0100, 32'h11223344, 4'hF, 32'h00000000, 2, 0, 1, 32'h11223344};
        vecs[2] = '{1'b0, 16'h0020, 32'hAABBCCDD, 4'h4, 32'h00000000, 2, 0, 1, 32'h00BB0000};
        vecs[3] = '{1'b1, 16'h0100, 32'h00000000, 4'h0, 32'h11223344, 3, 2, 0, 32'h11223344};
        vecs[4] = '{1'b0, 16'h0020, 32'h00000000, 4'h0, 32'h00BB0000, 3, 2, 0, 32'h00BB0000};
        vecs[5] = '{1'b1, 16'h0030, 32'hCAFEF00D, 4'h3, 32'h00000000, 2, 0, 1, 32'h1234F00D};
        vecs[6] = '{1'b0, 16'h0030, 32'h00000000, 4'h0, 32'h1234F00D, 3, 2, 0, 32'h1234F00D};

        preload(16'h0010, 32'hDEADBEEF);
        preload(16'h0020, 32'h00000000);
        preload(16'h0030, 32'h12345678);
        preload(16'h0100, 32'h00000000);

        // Reset state
        @(negedge clk);
        check("rst m0_ready", {31'b0, bus.m0_ready}, 32'h0);
        check("rst m1_ready", {31'b0, bus.m1_ready}, 32'h0);
        check("rst m0_rdata", bus.m0_rdata, 32'h0);
        check("rst m1_rdata", bus.m1_rdata, 32'h0);
        check("rst strobes", {29'b0, bus.extram_cs, bus.extram_oe, bus.extram_wstrb != 4'h0}, 32'h0);
        check("rst extram_a", 32'(bus.extram_a), 32'h0);
        check("rst extram_d_out", bus.extram_d_out, 32'h0);
        check("rst busy", {31'b0, busy}, 32'h0);
        nrst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Inputs change after the grant: original read must still complete.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h0010, 32'h0, 4'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0020, 32'hFFFFFFFF, 4'hF);
        c0 = 0;
        for (int k = 2; k <= BUDGET; k++) begin
            @(negedge clk);
            if (k == 2) begin
                check("late addr held", 32'(bus.extram_a), 32'h0010);
                check("late still read", {27'b0, bus.extram_oe, bus.extram_wstrb}, 32'h10);
            end
            if (bus.m0_ready) begin
                c0 = k;
                check("late rdata", bus.m0_rdata, 32'hDEADBEEF);
                break;
            end
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        check("late ready cycle", 32'(c0), 32'd3);
        check("late no write", mem[16'h0020], 32'h00BB0000);

        // Contention: m1 first, m0 after m1_ready plus one IDLE cycle.
        reset_dut();
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h0040, 32'h0A0A0A0A, 4'hF);
        drive(1'b1, 1'b1, 16'h0050, 32'h0B0B0B0B, 4'hF);
        c0 = 0; c1 = 0;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (bus.m1_ready) begin c1 = k; drive(1'b1, 1'b0, 16'h0, 32'h0, 4'h0); end
            if (bus.m0_ready) begin c0 = k; drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); end
            if (c0 != 0 && c1 != 0) break;
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
        check("contend m1 cycle", 32'(c1), 32'd2);
        check("contend m0 cycle", 32'(c0), 32'd5);
        check("contend m0 word", mem[16'h0040], 32'h0A0A0A0A);
        check("contend m1 word", mem[16'h0050], 32'h0B0B0B0B);

        // Both requesters held continuously for four transactions.
        reset_dut();
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h0060, 32'h00000006, 4'hF);
        drive(1'b1, 1'b1, 16'h0070, 32'h00000007, 4'hF);
        order = '0; n = 0;
        for (int i = 0; i < 4; i++) cyc[i] = 0;
        for (int k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            if (bus.m0_ready || bus.m1_ready) begin
                order[n] = bus.m1_ready;
                cyc[n]   = k;
                n++;
                if (n == 4) break;
            end
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
`ifdef EXTRAM_ARB_ROUND_ROBIN_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        check("held grant count", 32'(n), 32'd4);
        check("held grant order", {28'b0, order}, {28'b0, exp_order});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("held ready cycle %0d", i), 32'(cyc[i]), 32'(2 + 3 * i));
        end
        @(negedge clk);

        // Reset during the ACCESS phase of a read discards it.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h0010, 32'h0, 4'h0);
        @(negedge clk);
        check("mid-rst oe before", {31'b0, bus.extram_oe}, 32'h1);
        nrst = 1'b0;
        @(negedge clk);
        check("mid-rst strobes", {29'b0, bus.extram_cs, bus.extram_oe, bus.extram_wstrb != 4'h0}, 32'h0);
        check("mid-rst busy", {31'b0, busy}, 32'h0);
        drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
        nrst = 1'b1;
        seen_rdy = bus.m0_ready | bus.m1_ready;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen_rdy = seen_rdy | bus.m0_ready | bus.m1_ready;
        end
        check("mid-rst no ready", {31'b0, seen_rdy}, 32'h0);
        run_txn(vecs[0], "post-rst read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
